// File: rtl/subtractor_line_serial_pkg.sv
// ============================================================================
// Module      : subtractor_line_serial_pkg
// Description : Shared state encodings and sizing helpers for the serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package subtractor_line_serial_pkg;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Counter width never drops below one bit, even for a single-chunk build.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/subtractor_line_serial_full_subtractor.sv
// ============================================================================
// Module      : full_subtractor
// Description : One-bit full subtractor cell, d = a - b - bi with borrow out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor
    import subtractor_line_serial_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

`default_nettype wire

// File: rtl/subtractor_line_serial.sv
// ============================================================================
// Module      : subtractor_line_serial
// Description : Multi-cycle a0 - a1, CHUNK bits per clock with a carried borrow.
//               Optional SUB_OVERFLOW_EN adds a signed-overflow output ovf.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module subtractor_line_serial
    import subtractor_line_serial_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   diff
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int             NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int             CW     = cnt_width(NCHUNK);
    localparam logic [CW-1:0]  c_last = CW'(NCHUNK - 1);

    generate
        if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
            $error("subtractor_line_serial: CHUNK must divide WIDTH");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH:0]   r_diff;

    logic [31:0]      w_sh;
    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cb;
    logic [CHUNK-1:0] w_cd;
    logic [CHUNK:0]   w_bc;
    logic [WIDTH-1:0] w_ins;
    logic [WIDTH-1:0] w_msk;
    logic [WIDTH-1:0] w_work_nxt;

    // Chunk k of each operand is brought down to bit 0 by shifting.
    assign w_sh    = 32'(r_cnt) * 32'(CHUNK);
    assign w_ca    = CHUNK'(r_a >> w_sh);
    assign w_cb    = CHUNK'(r_b >> w_sh);
    assign w_bc[0] = r_borrow;

    generate
        for (genvar i = 0; i < CHUNK; i++) begin : g_fs
            full_subtractor u_fs (
                .a  (w_ca[i]),
                .b  (w_cb[i]),
                .bi (w_bc[i]),
                .d  (w_cd[i]),
                .bo (w_bc[i+1])
            );
        end
    endgenerate

    assign w_ins      = WIDTH'(w_cd) << w_sh;
    assign w_msk      = WIDTH'({CHUNK{1'b1}}) << w_sh;
    assign w_work_nxt = (r_work & ~w_msk) | w_ins;

`ifdef SUB_OVERFLOW_EN
    logic r_ovf;
    logic w_ovf;

    assign w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_work_nxt[WIDTH-1] != r_a[WIDTH-1]);
    assign ovf   = r_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if ((r_state == c_st_run) && (r_cnt == c_last)) begin
            r_ovf <= w_ovf;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_work   <= '0;
            r_diff   <= '0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (start) begin
                        r_a      <= a0;
                        r_b      <= a1;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        r_work   <= '0;
                        r_state  <= c_st_run;
                    end else begin
                        r_state  <= c_st_idle;
                    end
                end
                c_st_run: begin
                    r_work   <= w_work_nxt;
                    r_borrow <= w_bc[CHUNK];
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_diff  <= {w_bc[CHUNK], w_work_nxt};
                        r_state <= c_st_done;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign busy = (r_state == c_st_run);
    assign done = (r_state == c_st_done);
    assign diff = r_diff;

endmodule

`default_nettype wire
